// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared frame states, limits and helpers for the UART echo peer
package uart_pkg;

    localparam int MIN_BAUD = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] length);
        if (length < 4'd5) begin
            return 4'd5;
        end else if (length > 4'd8) begin
            return 4'd8;
        end
        return length;
    endfunction

    // Seeding with parity_type turns the even-parity XOR into odd parity.
    function automatic logic calc_parity(input logic [7:0] data, input logic [3:0] length,
                                         input logic parity_type);
        logic p;
        p = parity_type;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(length)) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_peer_tx.sv
// rtl/uart_peer_tx.sv - echo serialiser: start, data LSB first, optional parity, 1-2 stop bits
module uart_peer_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] baud,
    input  logic [3:0]  length,
    input  logic        parity_en,
    input  logic        parity_type,
    input  logic        stop2,
    input  logic        start_i,
    input  logic [7:0]  data_i,
    output logic        pop_o,
    output logic        tx_o,
    output logic        tx_busy,
    output logic        tx_done
);
    import uart_pkg::*;

    uart_state_t state_q, state_d;
    logic [16:0] cnt_q, cnt_d, baud_q, baud_d;
    logic [3:0]  bit_q, bit_d, len_q, len_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d, pen_q, pen_d, stop2_q, stop2_d, tx_q, tx_d;
    logic        bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            data_q  <= data_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 17'd1;
        baud_d  = baud_q;
        bit_d   = bit_q;
        len_d   = len_q;
        data_d  = data_q;
        par_d   = par_q;
        pen_d   = pen_q;
        stop2_d = stop2_q;
        tx_d    = tx_q;
        pop_o   = 1'b0;
        tx_done = 1'b0;
        bit_end = (cnt_q == baud_q - 17'd1);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (start_i) begin
                    // Parity is fixed from the full byte before the shift register consumes it.
                    pop_o   = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                    baud_d  = baud;
                    len_d   = length;
                    pen_d   = parity_en;
                    stop2_d = stop2;
                    data_d  = data_i;
                    par_d   = calc_parity(data_i, length, parity_type);
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == len_q - 4'd1) begin
                        bit_d = '0;
                        if (pen_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        data_d = data_q >> 1;
                        tx_d   = data_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == {3'b000, stop2_q}) begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_o    = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: rtl/uart_echo_peer.sv
// rtl/uart_echo_peer.sv - far-end UART peer: receives frames, checks them, echoes good bytes
module uart_echo_peer #(
    parameter int MIN_BAUD = uart_pkg::MIN_BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] baud,
    input  logic [3:0]  length,
    input  logic        parity_en,
    input  logic        parity_type,
    input  logic        stop2,
    input  logic        tx_en,
    input  logic        rx_i,
    output logic        tx_o,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        tx_busy,
    output logic        tx_done
);
    import uart_pkg::*;

    uart_state_t state_q, state_d;
    logic        s1_q, s2_q, prev_q;
    logic [16:0] cnt_q, cnt_d, baud_q, baud_d, baud_eff;
    logic [3:0]  bit_q, bit_d, len_q, len_d, len_eff;
    logic        pen_q, pen_d, ptype_q, ptype_d, stop2_q, stop2_d;
    logic [7:0]  shift_q, shift_d;
    logic        perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d;
    logic [7:0]  rx_data_q, rx_data_d, hold_q, hold_d;
    logic        rx_valid_q, rx_valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic        hold_full_q, hold_full_d;
    logic        fall, bit_end, half_end, ferr_now, pop;

    assign baud_eff = (baud < 17'(MIN_BAUD)) ? 17'(MIN_BAUD) : baud;
    assign len_eff  = clamp_len(length);
    assign fall     = prev_q & ~s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            len_q       <= '0;
            pen_q       <= 1'b0;
            ptype_q     <= 1'b0;
            stop2_q     <= 1'b0;
            shift_q     <= '0;
            perr_acc_q  <= 1'b0;
            ferr_acc_q  <= 1'b0;
            rx_data_q   <= '0;
            hold_q      <= '0;
            rx_valid_q  <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            s1_q        <= rx_i;
            s2_q        <= s1_q;
            prev_q      <= s2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            len_q       <= len_d;
            pen_q       <= pen_d;
            ptype_q     <= ptype_d;
            stop2_q     <= stop2_d;
            shift_q     <= shift_d;
            perr_acc_q  <= perr_acc_d;
            ferr_acc_q  <= ferr_acc_d;
            rx_data_q   <= rx_data_d;
            hold_q      <= hold_d;
            rx_valid_q  <= rx_valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 17'd1;
        baud_d      = baud_q;
        bit_d       = bit_q;
        len_d       = len_q;
        pen_d       = pen_q;
        ptype_d     = ptype_q;
        stop2_d     = stop2_q;
        shift_d     = shift_q;
        perr_acc_d  = perr_acc_q;
        ferr_acc_d  = ferr_acc_q;
        rx_data_d   = rx_data_q;
        hold_d      = hold_q;
        rx_valid_d  = 1'b0;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        ovr_d       = 1'b0;
        // A pop in the same cycle frees the slot before any write lands.
        hold_full_d = hold_full_q & ~pop;
        bit_end     = (cnt_q == baud_q - 17'd1);
        half_end    = (cnt_q == (baud_q >> 1) - 17'd1);
        ferr_now    = ferr_acc_q | ~s2_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d    = START;
                    baud_d     = baud_eff;
                    len_d      = len_eff;
                    pen_d      = parity_en;
                    ptype_d    = parity_type;
                    stop2_d    = stop2;
                    shift_d    = '0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end
            end
            START: begin
                if (half_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = s2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d                = '0;
                    shift_d[bit_q[2:0]]  = s2_q;
                    if (bit_q == len_q - 4'd1) begin
                        bit_d   = '0;
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    perr_acc_d = (s2_q != calc_parity(shift_q, len_q, ptype_q));
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d      = '0;
                    ferr_acc_d = ferr_now;
                    if (bit_q == {3'b000, stop2_q}) begin
                        state_d    = IDLE;
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                        perr_d     = perr_acc_q;
                        ferr_d     = ferr_now;
                        if (!perr_acc_q && !ferr_now) begin
                            if (hold_full_q && !pop) begin
                                ovr_d = 1'b1;
                            end else begin
                                hold_d      = shift_q;
                                hold_full_d = 1'b1;
                            end
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    uart_peer_tx u_tx (
        .clk         (clk),
        .rst         (rst),
        .baud        (baud_eff),
        .length      (len_eff),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .start_i     (hold_full_q & tx_en),
        .data_i      (hold_q),
        .pop_o       (pop),
        .tx_o        (tx_o),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_echo_peer.sv
// tb/tb_uart_echo_peer.sv - directed self-checking bench for uart_echo_peer
module tb_uart_echo_peer;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] baud = 17'(B);
    logic [3:0]  length = 4'd8;
    logic        parity_en = 1'b0;
    logic        parity_type = 1'b0;
    logic        stop2 = 1'b0;
    logic        tx_en = 1'b1;
    logic        rx_i = 1'b1;
    logic        tx_o, rx_valid, parity_err, frame_err, overrun, tx_busy, tx_done;
    logic [7:0]  rx_data;

    int tests = 0;
    int fails = 0;

    int n_rxv = 0, n_perr_v = 0, n_ferr_v = 0, n_perr = 0, n_ferr = 0, n_ovr = 0;
    int n_busy = 0, n_txlow = 0;
    logic [7:0] last_data = '0;

    uart_echo_peer dut (
        .clk         (clk),
        .rst         (rst),
        .baud        (baud),
        .length      (length),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .tx_en       (tx_en),
        .rx_i        (rx_i),
        .tx_o        (tx_o),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_rxv     <= n_rxv + 1;
                last_data <= rx_data;
            end
            if (parity_err) n_perr <= n_perr + 1;
            if (frame_err) n_ferr <= n_ferr + 1;
            if (parity_err && rx_valid) n_perr_v <= n_perr_v + 1;
            if (frame_err && rx_valid) n_ferr_v <= n_ferr_v + 1;
            if (overrun && rx_valid) n_ovr <= n_ovr + 1;
            if (tx_busy) n_busy <= n_busy + 1;
            if (!tx_o) n_txlow <= n_txlow + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_i = v;
        repeat (B) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int len, input bit pen, input logic pbit,
                              input int nstop, input logic sval);
        drive_bit(1'b0);
        for (int i = 0; i < len; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        for (int s = 0; s < nstop; s++) drive_bit(sval);
        rx_i = 1'b1;
    endtask

    // Waits for the echo start bit, then samples each bit mid-period.
    task automatic capture(input int nbits, output logic [11:0] bits, output logic found,
                           output logic prev_v, output logic done_end);
        bits = '0; found = 1'b0; prev_v = 1'b0; done_end = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                found = 1'b1;
                break;
            end
            prev_v = rx_valid;
        end
        if (found) begin
            for (int c = 0; c < nbits * B; c++) begin
                if (c != 0) @(negedge clk);
                if (c % B == B / 2) bits[c / B] = tx_o;
                if (c == nbits * B - 1) done_end = tx_done;
            end
        end
    endtask

    initial begin
        logic [11:0] bits;
        logic found, prev_v, done_end, txo_before;
        int s_rxv, s_perr_v, s_ferr_v, s_perr, s_ferr, s_ovr, s_busy, s_txlow;

        repeat (3) @(negedge clk);
        check("reset_tx_o", 32'(tx_o), 32'h1);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_tx_busy", 32'(tx_busy), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_pulses", 32'({parity_err, frame_err, overrun, tx_done}), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        s_rxv = n_rxv; s_perr = n_perr; s_ferr = n_ferr;
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
            capture(10, bits, found, prev_v, done_end);
        join
        repeat (4) @(negedge clk);
        check("basic_found", 32'(found), 32'h1);
        check("basic_latency", 32'(prev_v), 32'h1);
        check("basic_frame", 32'(bits), 32'h34A);
        check("basic_done", 32'(done_end), 32'h1);
        check("basic_rx_data", 32'(last_data), 32'hA5);
        check("basic_rxv", 32'(n_rxv - s_rxv), 32'h1);
        check("basic_noerr", 32'((n_perr - s_perr) + (n_ferr - s_ferr)), 32'h0);
        repeat (10) @(negedge clk);

        length = 4'd5; parity_en = 1'b1; parity_type = 1'b1; stop2 = 1'b1;
        s_perr = n_perr; s_ferr = n_ferr;
        fork
            send_frame(8'h13, 5, 1'b1, 1'b0, 2, 1'b1);
            capture(9, bits, found, prev_v, done_end);
        join
        repeat (4) @(negedge clk);
        check("odd5_frame", 32'(bits), 32'h1A6);
        check("odd5_done", 32'(done_end), 32'h1);
        check("odd5_rx_data", 32'(last_data), 32'h13);
        check("odd5_noerr", 32'((n_perr - s_perr) + (n_ferr - s_ferr)), 32'h0);
        repeat (10) @(negedge clk);

        length = 4'd8; parity_en = 1'b1; parity_type = 1'b0; stop2 = 1'b0;
        s_rxv = n_rxv; s_perr_v = n_perr_v; s_busy = n_busy; s_txlow = n_txlow;
        send_frame(8'h07, 8, 1'b1, 1'b0, 1, 1'b1);
        repeat (300) @(negedge clk);
        check("perr_with_valid", 32'(n_perr_v - s_perr_v), 32'h1);
        check("perr_rxv", 32'(n_rxv - s_rxv), 32'h1);
        check("perr_no_busy", 32'(n_busy - s_busy), 32'h0);
        check("perr_no_txlow", 32'(n_txlow - s_txlow), 32'h0);

        parity_en = 1'b0;
        s_ferr_v = n_ferr_v; s_busy = n_busy;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0);
        repeat (300) @(negedge clk);
        check("ferr_with_valid", 32'(n_ferr_v - s_ferr_v), 32'h1);
        check("ferr_no_busy", 32'(n_busy - s_busy), 32'h0);

        s_rxv = n_rxv; s_perr = n_perr; s_ferr = n_ferr; s_ovr = n_ovr;
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_rxv", 32'(n_rxv - s_rxv), 32'h0);
        check("glitch_no_err", 32'((n_perr - s_perr) + (n_ferr - s_ferr) + (n_ovr - s_ovr)), 32'h0);

        tx_en = 1'b0;
        s_rxv = n_rxv; s_ovr = n_ovr; s_busy = n_busy;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (5) @(negedge clk);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (50) @(negedge clk);
        check("ovr_pulse", 32'(n_ovr - s_ovr), 32'h1);
        check("ovr_rxv", 32'(n_rxv - s_rxv), 32'h2);
        check("ovr_rx_data", 32'(last_data), 32'h22);
        check("ovr_no_busy", 32'(n_busy - s_busy), 32'h0);
        tx_en = 1'b1;
        capture(10, bits, found, prev_v, done_end);
        check("ovr_echo_frame", 32'(bits), 32'h222);
        s_txlow = n_txlow;
        repeat (300) @(negedge clk);
        check("ovr_single_echo", 32'(n_txlow - s_txlow), 32'h0);

        txo_before = 1'b1;
        fork
            send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                capture(0, bits, found, prev_v, done_end);
                repeat (72) @(negedge clk);
                txo_before = tx_o;
                rst = 1'b1;
                #1;
            end
        join
        check("rst_txo_was_low", 32'(txo_before), 32'h0);
        check("rst_tx_o", 32'(tx_o), 32'h1);
        check("rst_busy", 32'(tx_busy), 32'h0);
        check("rst_pulses", 32'({rx_valid, parity_err, frame_err, overrun, tx_done}), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        fork
            send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
            capture(10, bits, found, prev_v, done_end);
        join
        check("post_rst_frame", 32'(bits), 32'h2B4);
        check("post_rst_done", 32'(done_end), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_echo_peer.md
# uart_echo_peer

Far-end UART peer for the serial line driven by the UART top-level: a single-clock block that deserialises incoming frames, checks parity and stop bits, and retransmits each good byte back on its own serial output with the same framing. It uses the same run-time frame configuration as the transmitter/receiver pair (baud, length, parity, stop bits). It serves as the loopback/responder end in system-level UART verification.

## Interface
Parameters:
- MIN_BAUD, 4, smallest legal bit period in clk cycles; smaller `baud` values are clamped to this.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- baud  in  17  bit period in clk cycles.
- length  in  4  data bits per frame; 5..8 legal, <5 treated as 5, >8 as 8.
- parity_en  in  1  parity bit present.
- parity_type  in  1  0 = even, 1 = odd.
- stop2  in  1  0 = one stop bit, 1 = two.
- tx_en  in  1  echo enable; while low, no new echo frame starts.
- rx_i  in  1  serial input, idle high, asynchronous to clk.
- tx_o  out  1  serial echo output, idle high.
- rx_data  out  8  last received byte, LSB-aligned, unused upper bits 0.
- rx_valid  out  1  one-cycle pulse: frame received, `rx_data` updated.
- parity_err  out  1  one-cycle pulse with `rx_valid` on parity mismatch.
- frame_err  out  1  one-cycle pulse with `rx_valid` on a low stop bit.
- overrun  out  1  one-cycle pulse: good frame dropped, holding register full.
- tx_busy  out  1  echo frame in progress.
- tx_done  out  1  one-cycle pulse at end of last echo stop bit.

## Operation
- Reset: tx_o=1; all other outputs 0. Both FSMs go to IDLE and the holding register is emptied. Asserting reset mid-frame aborts both directions immediately; tx_o goes high asynchronously.
- Config (baud, length, parity, stop2) is latched at the start of each RX or TX frame. Changes mid-frame do not affect the frame in flight.
- rx_i passes through a 2-flop synchroniser. Start is detected on a synchronised 1→0 transition.
- RX FSM states: IDLE → START → DATA → PARITY (only if parity_en) → STOP → IDLE.
  - START: wait baud/2 (integer floor) cycles, then resample. If the line is high, it is a false start; return to IDLE with no outputs.
  - Each subsequent bit is sampled exactly baud cycles after the previous sample. Data arrives LSB first.
  - PARITY: compare against the XOR of the data bits (inverted if odd).
  - STOP: every stop bit must sample 1, otherwise frame_err. All stop bits are sampled even after a failure.
- rx_valid and any error pulses fire the cycle after the final stop sample. RX returns to IDLE and can detect a new start on the next cycle.
- Good frame (no errors): the byte is written into a 1-entry holding register. If that register is already full, assert overrun and drop the new byte; the held byte is kept.
- Errored frames are never echoed.
- TX FSM states: IDLE → START → DATA → PARITY (if enabled) → STOP(1 or 2) → IDLE.
  - Starts when the holding register is full and tx_en=1 in IDLE. The start cycle pops the register.
  - Each bit is driven for exactly baud cycles. Parity is computed with the same rule as RX.
  - tx_done pulses on the last cycle of the final stop bit. A new frame may start on the following cycle.
  - tx_en going low mid-frame does not abort the frame in flight.
- Counters: the bit-period counter is 17 bits and the bit index is 4 bits. There is no wrap inside a frame.

## Timing
- Frame length in bits = 1 + length + parity_en + 1 + stop2.
- Echo latency: the TX start bit appears on tx_o 1 cycle after rx_valid, provided TX is idle and tx_en=1.
- rx_i to start detect: 2 cycles of synchroniser delay plus 1 edge-detect cycle.
- If rx_valid for a good frame and the TX pop land in the same cycle, the write wins over overrun: the pop frees the slot first.

## Structure
- Shared package uart_pkg contains:
  - enum `uart_state_t` {IDLE, START, DATA, PARITY, STOP};
  - function `calc_parity(data, length, parity_type)`;
  - function `clamp_len`;
  - localparam MIN_BAUD.
- One sub-module, uart_peer_tx: serialiser with the TX FSM. Instantiated by uart_echo_peer, which holds the synchroniser, RX FSM and holding register.

## Test plan
- Basic echo: baud=16, length=8, no parity, stop2=0, rx_i carries 0xA5.
  - Expect rx_valid with rx_data=0xA5.
  - Expect a 10-bit frame for 0xA5 on tx_o (160 cycles), starting 1 cycle after rx_valid.
  - Expect tx_done at its end.
- Short frame with odd parity: length=5, parity_en=1, parity_type=1, stop2=1, data 0x13 with correct parity.
  - Expect rx_data=0x13 and no errors.
  - Expect a 9-bit echo frame with the parity bit equal to 0.
- Parity error: even parity, data 0x07 sent with parity bit 0.
  - Expect parity_err and rx_valid pulses together.
  - Expect no echo: tx_o stays high and tx_busy stays 0.
- Frame error and glitch:
  - A frame with its stop bit driven low gives a frame_err pulse and no echo.
  - A separate 3-cycle low pulse on rx_i (baud=16) gives no pulses at all.
- Overrun: tx_en=0, send 0x11 then 0x22.
  - Expect an overrun pulse on the second frame.
  - Raise tx_en: tx_o echoes 0x11 only.
- Reset mid-operation: assert rst during TX data bit 3.
  - Expect tx_o=1 immediately and all pulses 0.
  - After release, a fresh 0x5A frame is echoed correctly.
